// File: rtl/mac_dot_seq.sv
// mac_dot_seq: dot-product sequencer in front of an external MAC unit.
//
// A job gives a vector length and an add/subtract mode. The block then takes
// one signed (a, b) operand pair per beat and issues one MAC step for each.
// After the last step it captures the MAC accumulator and presents it on a
// valid/ready result port. The accumulator register itself is in the MAC.
//
// Build option: DOTSEQ_BIAS_EN adds the i_bias port. The bias is latched
// with i_start and loaded as the initial accumulator value. Without the
// option, the initial value is always 0.
//
// Ports
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_start, i_len, i_sub    job request, length, subtract mode
//   i_bias                   initial accumulator value (DOTSEQ_BIAS_EN only)
//   o_busy                   high whenever a job is in progress
//   i_valid, i_a, i_b        operand stream; o_ready accepts a pair
//   o_mac_*                  MAC operands and controls (combinational)
//   i_mac_result             registered MAC accumulator
//   o_valid, o_result        result, accepted by i_ready
//
// state | meaning
// IDLE  | waiting for i_start
// ACC   | issuing MAC steps (cnt_q=0: single load-only cycle for len=0)
// DRAIN | MAC output settled, capture into o_result
// DONE  | o_valid high until i_ready
module mac_dot_seq #(
    parameter int ABIT = 8,
    parameter int BBIT = 8,
    parameter int EBIT = 8,
    parameter int LBIT = 8,
    localparam int TBIT = ABIT + BBIT + EBIT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [LBIT-1:0] i_len,
    input  logic            i_sub,
`ifdef DOTSEQ_BIAS_EN
    input  logic [TBIT-1:0] i_bias,
`endif
    output logic            o_busy,
    input  logic            i_valid,
    input  logic [ABIT-1:0] i_a,
    input  logic [BBIT-1:0] i_b,
    output logic            o_ready,
    output logic [ABIT-1:0] o_mac_a,
    output logic [BBIT-1:0] o_mac_b,
    output logic [TBIT-1:0] o_mac_loadVal,
    output logic            o_mac_load,
    output logic            o_mac_add,
    output logic            o_mac_useMul,
    input  logic [TBIT-1:0] i_mac_result,
    output logic            o_valid,
    output logic [TBIT-1:0] o_result,
    input  logic            i_ready
);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [LBIT-1:0] cnt_q;
    logic            first_q;
    logic            sub_q;
    logic [TBIT-1:0] result_q;
    logic [TBIT-1:0] init_val;
    logic            beat;
    logic            load_only;

`ifdef DOTSEQ_BIAS_EN
    logic [TBIT-1:0] bias_q;
    assign init_val = bias_q;
`else
    assign init_val = '0;
`endif

    // Entering ACC with a zero count marks the len=0 load-only cycle.
    assign load_only = (state_q == ACC) && (cnt_q == '0);
    assign o_ready   = (state_q == ACC) && (cnt_q != '0);
    assign beat      = i_valid && o_ready;
    assign o_busy    = (state_q != IDLE);
    assign o_valid   = (state_q == DONE);
    assign o_result  = result_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        o_mac_a       = '0;
        o_mac_b       = '0;
        o_mac_loadVal = '0;
        o_mac_load    = 1'b0;
        o_mac_add     = 1'b1;
        o_mac_useMul  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) state_d = ACC;
            end
            ACC: begin
                if (load_only) begin
                    o_mac_load    = 1'b1;
                    o_mac_loadVal = init_val;
                    state_d       = DRAIN;
                end else if (beat) begin
                    o_mac_a       = i_a;
                    o_mac_b       = i_b;
                    o_mac_useMul  = 1'b1;
                    o_mac_add     = ~sub_q;
                    o_mac_load    = first_q;
                    o_mac_loadVal = first_q ? init_val : '0;
                    if (cnt_q == LBIT'(1)) state_d = DRAIN;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            first_q  <= 1'b0;
            sub_q    <= 1'b0;
            result_q <= '0;
`ifdef DOTSEQ_BIAS_EN
            bias_q   <= '0;
`endif
        end else begin
            if ((state_q == IDLE) && i_start) begin
                cnt_q   <= i_len;
                first_q <= 1'b1;
                sub_q   <= i_sub;
`ifdef DOTSEQ_BIAS_EN
                bias_q  <= i_bias;
`endif
            end else if (beat || load_only) begin
                first_q <= 1'b0;
                if (beat) cnt_q <= cnt_q - LBIT'(1);
            end
            if (state_q == DRAIN) result_q <= i_mac_result;
        end
    end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Dot-product sequencer that sits directly upstream of the multiply-accumulate unit and drives its operand and control inputs. It accepts a job (vector length, add/subtract mode), consumes a valid/ready stream of signed operand pairs, issues one MAC step per accepted pair, and returns the final accumulator value on a valid/ready result port. The accumulator register itself lives in the MAC; this block only sequences it and captures its output.

## Interface
- ABIT, 8, signed width of operand a
- BBIT, 8, signed width of operand b
- EBIT, 8, accumulator guard bits; TBIT = ABIT+BBIT+EBIT
- LBIT, 8, width of the vector-length field
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  job request, sampled only in IDLE
- i_len  in  LBIT  number of operand pairs (unsigned), latched with i_start
- i_sub  in  1  1: accumulate −a·b; 0: accumulate +a·b; latched with i_start
- i_bias  in  TBIT  signed initial value, latched with i_start (only with DOTSEQ_BIAS_EN)
- o_busy  out  1  high in every state except IDLE
- i_valid, i_a[ABIT], i_b[BBIT]  in  operand stream
- o_ready  out  1  high only in ACC
- o_mac_a  out  ABIT; o_mac_b  out  BBIT  operands to MAC
- o_mac_loadVal  out  TBIT  initial accumulator value
- o_mac_load, o_mac_add, o_mac_useMul  out  1 each  MAC controls
- i_mac_result  in  TBIT  MAC registered accumulator
- o_valid  out  1; o_result  out  TBIT  result; i_ready  in  1  result accept

## Operation
- States: IDLE, ACC, DRAIN, DONE.
- IDLE: i_start=1 latches len/sub/bias, sets first flag. len≠0 → ACC. len=0 → issue one load-only MAC cycle (load=1, useMul=0, loadVal=0 or bias) → DRAIN.
- ACC: beat = i_valid & o_ready. On beat: o_mac_a/b = i_a/i_b, useMul=1, add=~sub, load=first, loadVal=0 (or bias); first cleared; remaining count decrements. Non-beat cycles: useMul=0, load=0 (MAC holds). Beat with count=1 → DRAIN.
- DRAIN: one cycle; o_result <= i_mac_result → DONE.
- DONE: o_valid=1, o_result stable until i_valid&… i.e. o_valid & i_ready → IDLE.
- MAC drive outputs are combinational from state and i_a/i_b; in IDLE/DRAIN/DONE (except len=0 load cycle): a=b=0, loadVal=0, load=0, useMul=0, add=1.
- Arithmetic wraps modulo 2^TBIT in the MAC; no saturation. Overflow-free when EBIT ≥ LBIT.
- i_start outside IDLE ignored; i_len/i_sub/i_bias changes after latch ignored.
- Reset (any time, including mid-job): state IDLE, count 0, first 0, o_valid 0, o_result 0, o_busy 0, o_ready 0. MAC contents are don't-care; next job always loads.

## Timing
- Beat k accepted in cycle N → MAC register updated at end of N.
- Last beat in cycle N → DRAIN in N+1 → o_valid high from N+2.
- len=0: start in cycle S → load cycle S+1... precisely: start sampled at S, load cycle S+1 (state marks load), DRAIN S+2, o_valid from S+3.
- Minimum job: 1 start cycle + len beat cycles + DRAIN + ≥1 DONE cycle; back-to-back i_start accepted the cycle after result handshake.

## Configuration
- DOTSEQ_BIAS_EN defined: i_bias port present, latched at start, used as o_mac_loadVal on the first MAC step (or the len=0 load cycle).
- Undefined: no i_bias port; loadVal is always 0.

## Test plan
- len=3, sub=0, pairs (2,3),(−4,5),(7,−1), continuous valid → o_result=−21, o_valid exactly 2 cycles after last beat.
- Same with sub=1 → o_result=21.
- len=3 pairs as above with 2 idle cycles between beats → o_result=−21; useMul=0 and load=0 in every idle cycle.
- len=0 → o_result=0 (=100 with DOTSEQ_BIAS_EN, bias=100); DOTSEQ_BIAS_EN, bias=100, len=1, (3,4) → 112.
- Result held with i_ready=0 for 5 cycles plus i_start pulses → o_valid/o_result stable, no new job; i_ready=1 → IDLE next cycle.
- Assert i_rst_n=0 after 2 of 4 beats → o_busy/o_ready/o_valid 0 immediately; then len=1, (−128,−128) → o_result=16384.
